// File: rtl/cam_key_scanner_pkg.sv
// rtl/cam_key_scanner_pkg.sv - shared parameters and state encoding for the key scanner
package cam_key_scanner_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 16;
    localparam int IDX_W_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } scan_state_e;

endpackage

// File: rtl/eq_cmp32.sv
// rtl/eq_cmp32.sv - combinational equality of two keys (XNOR per bit, full AND reduction)
module eq_cmp32
    import cam_key_scanner_pkg::*;
#(
    parameter int W = DATA_W_DEF
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         eq_o
);

    assign eq_o = &(a_i ~^ b_i);

endmodule

// File: rtl/cam_key_scanner.sv
// rtl/cam_key_scanner.sv - sequential key-table search returning the lowest matching index
module cam_key_scanner
    import cam_key_scanner_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_key,
    input  logic              wr_vld,
    input  logic              clr_all,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_key,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic              busy
);

    scan_state_e       state_q, state_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              hit_q, hit_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [DATA_W-1:0] key_tbl_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;

    logic key_eq;
    logic entry_hit;
    logic last_entry;

    eq_cmp32 #(.W(DATA_W)) u_cmp (
        .a_i  (key_tbl_q[scan_idx_q]),
        .b_i  (key_q),
        .eq_o (key_eq)
    );

    assign entry_hit  = vld_q[scan_idx_q] & key_eq;
    assign last_entry = (scan_idx_q == IDX_W'(DEPTH - 1));

    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        key_d      = key_q;
        hit_d      = hit_q;
        idx_d      = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    key_d      = req_key;
                    scan_idx_d = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (entry_hit) begin
                    hit_d   = 1'b1;
                    idx_d   = scan_idx_q;
                    state_d = ST_RESP;
                end else if (last_entry) begin
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            scan_idx_q <= '0;
            key_q      <= '0;
            hit_q      <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            key_q      <= key_d;
            hit_q      <= hit_d;
            idx_q      <= idx_d;
        end
    end

    // Valid bits are reset; clr_all overrides a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (clr_all) begin
            vld_q <= '0;
        end else if (wr_en) begin
            vld_q[wr_addr] <= wr_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr_all) begin
            key_tbl_q[wr_addr] <= wr_key;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q == ST_SCAN) || (state_q == ST_RESP);
    assign rsp_hit   = rsp_valid & hit_q;
    assign rsp_idx   = rsp_valid ? idx_q : '0;

endmodule

// File: tb/tb_cam_key_scanner.sv
// tb/tb_cam_key_scanner.sv - randomized and directed self-checking bench for cam_key_scanner
module tb_cam_key_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_key = '0;
    logic        wr_vld = 1'b0;
    logic        clr_all = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_key = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_hit;
    logic [3:0]  rsp_idx;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    cam_key_scanner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_key    (wr_key),
        .wr_vld    (wr_vld),
        .clr_all   (clr_all),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_key   (req_key),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_idx   (rsp_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: a table of 16 entries, and a search that examines entry k
    // in the k-th cycle after acceptance against the table as it stands then.
    bit [31:0] m_key [16];
    bit [15:0] m_vld = '0;
    bit        m_searching = 1'b0;
    bit        m_answered = 1'b0;
    int        m_pos = 0;
    bit [31:0] m_skey = '0;
    bit        m_hit = 1'b0;
    int        m_idx = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld = '0;
            m_searching = 1'b0;
            m_answered = 1'b0;
        end else begin
            if (m_answered) begin
                if (rsp_ready) m_answered = 1'b0;
            end else if (m_searching) begin
                if (m_vld[m_pos] && m_key[m_pos] == m_skey) begin
                    m_hit = 1'b1; m_idx = m_pos;
                    m_searching = 1'b0; m_answered = 1'b1;
                end else if (m_pos == 15) begin
                    m_hit = 1'b0; m_idx = 0;
                    m_searching = 1'b0; m_answered = 1'b1;
                end else begin
                    m_pos++;
                end
            end else if (req_valid) begin
                m_searching = 1'b1; m_pos = 0; m_skey = req_key;
            end
            if (clr_all) m_vld = '0;
            else if (wr_en) begin
                m_key[wr_addr] = wr_key;
                m_vld[wr_addr] = wr_vld;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, !(m_searching || m_answered)});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_answered});
            chk("busy", {31'b0, busy}, {31'b0, m_searching || m_answered});
            chk("rsp_hit", {31'b0, rsp_hit}, {31'b0, m_answered && m_hit});
            chk("rsp_idx", {28'b0, rsp_idx}, m_answered ? 32'(m_idx) : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic write(input int a, input logic [31:0] k, input logic v);
        wr_en = 1'b1; wr_addr = a[3:0]; wr_key = k; wr_vld = v;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_ready();
        int i = 0;
        while (!req_ready && i < 60) begin step(); i++; end
        chk("wait_ready", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic drain();
        int i = 0;
        while (busy && i < 60) begin step(); i++; end
        chk("drain", {31'b0, busy}, 32'd0);
    endtask

    // Searches k; optionally writes wk to entry wa while in cycle wr_at after acceptance.
    task automatic search(input string nm, input logic [31:0] k, input bit eh, input int ei,
                          input int elat, input int wr_at, input int wa, input logic [31:0] wk);
        int n;
        bit got;
        wait_ready();
        req_valid = 1'b1; req_key = k; rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        n = 1; got = 1'b0;
        while (n < 40) begin
            if (rsp_valid) begin got = 1'b1; break; end
            if (n == wr_at) begin
                wr_en = 1'b1; wr_addr = wa[3:0]; wr_key = wk; wr_vld = 1'b1;
            end else wr_en = 1'b0;
            step();
            n++;
        end
        wr_en = 1'b0;
        chk({nm, " seen"}, {31'b0, got}, 32'd1);
        chk({nm, " latency"}, 32'(n), 32'(elat));
        chk({nm, " hit"}, {31'b0, rsp_hit}, {31'b0, eh});
        chk({nm, " idx"}, {28'b0, rsp_idx}, 32'(ei));
        step();
    endtask

    function automatic logic [31:0] pick_key();
        case ($urandom_range(0, 3))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h8000_0001;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    initial begin
        logic hold_hit;
        logic [3:0] hold_idx;
        int n;

        #2;
        chk("reset req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset rsp_idx", {28'b0, rsp_idx}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        search("empty", 32'hDEAD_BEEF, 1'b0, 0, 17, -1, 0, 0);

        write(5, 32'hDEAD_BEEF, 1'b1);
        write(9, 32'hDEAD_BEEF, 1'b1);
        search("dup", 32'hDEAD_BEEF, 1'b1, 5, 7, -1, 0, 0);

        write(3, 32'h0000_0001, 1'b1);
        search("bit31", 32'h8000_0001, 1'b0, 0, 17, -1, 0, 0);
        search("low1", 32'h0000_0001, 1'b1, 3, 5, -1, 0, 0);

        write(0, 32'h0000_0000, 1'b0);
        search("zero invalid", 32'h0000_0000, 1'b0, 0, 17, -1, 0, 0);
        write(11, 32'h0000_0000, 1'b1);
        search("zero valid", 32'h0000_0000, 1'b1, 11, 13, -1, 0, 0);

        search("write ahead", 32'hCAFE_F00D, 1'b1, 8, 10, 3, 8, 32'hCAFE_F00D);
        search("write behind", 32'h1234_5678, 1'b0, 0, 17, 7, 4, 32'h1234_5678);

        // Response held back, then a request presented in the handshake cycle.
        wait_ready();
        req_valid = 1'b1; req_key = 32'hDEAD_BEEF; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin step(); n++; end
        hold_hit = rsp_hit; hold_idx = rsp_idx;
        repeat (10) begin
            step();
            chk("hold valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold hit", {31'b0, rsp_hit}, {31'b0, hold_hit});
            chk("hold idx", {28'b0, rsp_idx}, {28'b0, hold_idx});
            chk("hold req_ready", {31'b0, req_ready}, 32'd0);
        end
        chk("hold hit value", {31'b0, hold_hit}, 32'd1);
        chk("hold idx value", {28'b0, hold_idx}, 32'd5);
        req_valid = 1'b1; req_key = 32'h8000_0001; rsp_ready = 1'b1;
        step();
        chk("handshake no accept", {31'b0, busy}, 32'd0);
        step();
        req_valid = 1'b0;
        chk("accept after handshake", {31'b0, busy}, 32'd1);
        drain();

        // Reset while scanning entry 4 of a search that would hit at 5.
        wait_ready();
        req_valid = 1'b1; req_key = 32'hDEAD_BEEF;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midreset busy", {31'b0, busy}, 32'd0);
        chk("midreset req_ready", {31'b0, req_ready}, 32'd1);
        chk("midreset rsp_hit", {31'b0, rsp_hit}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        search("after reset", 32'hDEAD_BEEF, 1'b0, 0, 17, -1, 0, 0);

        write(2, 32'h5A5A_A5A5, 1'b1);
        clr_all = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; wr_key = 32'h5A5A_A5A5; wr_vld = 1'b1;
        step();
        clr_all = 1'b0; wr_en = 1'b0;
        search("clr_all wins", 32'h5A5A_A5A5, 1'b0, 0, 17, -1, 0, 0);

        repeat (2000) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_key   = pick_key();
            wr_en     = ($urandom_range(0, 4) == 0);
            wr_addr   = 4'($urandom_range(0, 15));
            wr_key    = pick_key();
            wr_vld    = ($urandom_range(0, 4) != 0);
            clr_all   = ($urandom_range(0, 99) == 0);
            rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        req_valid = 1'b0; wr_en = 1'b0; clr_all = 1'b0; rsp_ready = 1'b1;
        drain();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
